// File: rtl/integral_image_builder.sv
// Integral-image builder: turns a raster pixel stream into a stored integral image
// and serves it through a fixed 3-cycle read port. Optional macro: II_RANGE_CHECK_EN.
module integral_image_builder #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int PIX_W  = 4,
  parameter int II_W   = 21,
  parameter int ADDR_W = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_valid,
  input  logic [PIX_W-1:0]       pix_data,
  input  logic                   frame_start,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic signed [II_W-1:0] rd_data,
  output logic                   frame_ready,
  output logic                   build_busy,
  output logic                   overrun
`ifdef II_RANGE_CHECK_EN
  ,output logic                  rd_err
`endif
);
  localparam int XW   = $clog2(WIDTH);
  localparam int YW   = $clog2(HEIGHT);
  localparam int NPIX = WIDTH * HEIGHT;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUILD = 2'd1;
  localparam logic [1:0] READY = 2'd2;

  logic [1:0]        state;
  logic [XW-1:0]     x, cx;
  logic [YW-1:0]     y, cy;
  logic [ADDR_W-1:0] addr, caddr;
  logic [11:0]       row_sum, rs_n;
  logic [II_W-1:0]   ii;
  logic              start, accept, last;

  logic [II_W-1:0]   line_buf [WIDTH];
  logic [II_W-1:0]   ram      [NPIX];

  logic              wr_en, wr_last;
  logic [ADDR_W-1:0] wr_addr;
  logic [II_W-1:0]   wr_data;

  // A frame_start pixel always restarts at (0,0), whatever the counters say.
  assign start  = pix_valid && frame_start;
  assign accept = start || (pix_valid && state == BUILD);
  assign cx     = start ? '0 : x;
  assign cy     = start ? '0 : y;
  assign caddr  = start ? '0 : addr;
  assign last   = (cx == XW'(WIDTH - 1)) && (cy == YW'(HEIGHT - 1));
  assign rs_n   = ((cx == '0) ? 12'd0 : row_sum) + 12'(pix_data);
  assign ii     = II_W'(rs_n) + ((cy == '0) ? {II_W{1'b0}} : line_buf[cx]);

  assign build_busy = (state == BUILD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      addr        <= '0;
      row_sum     <= '0;
      wr_en       <= 1'b0;
      wr_last     <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_ready <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      wr_en   <= accept;
      wr_last <= accept && last;
      if (accept) begin
        wr_addr <= caddr;
        wr_data <= ii;
        row_sum <= rs_n;
        if (last) begin
          state <= READY;
          x     <= '0;
          y     <= '0;
          addr  <= '0;
        end else begin
          state <= BUILD;
          addr  <= caddr + ADDR_W'(1);
          if (cx == XW'(WIDTH - 1)) begin
            x <= '0;
            y <= cy + YW'(1);
          end else begin
            x <= cx + XW'(1);
            y <= cy;
          end
        end
      end
      if (start && state == BUILD) overrun <= 1'b1;
      // Ready follows the committed write of the last pixel; a restart wins.
      if (start)        frame_ready <= 1'b0;
      else if (wr_last) frame_ready <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !rst) line_buf[cx] <= ii;
    if (wr_en && !rst)  ram[wr_addr] <= wr_data;
  end

  // Read port: address reg -> RAM read reg -> output reg. Write-first is not
  // wanted, so a same-cycle read of the written address sees the old word.
  logic [ADDR_W-1:0] ra_q;
  logic [II_W-1:0]   ram_q;
`ifdef II_RANGE_CHECK_EN
  logic oor_q, oor_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      ra_q    <= '0;
      ram_q   <= '0;
      oor_q   <= 1'b0;
      oor_q2  <= 1'b0;
      rd_data <= '0;
      rd_err  <= 1'b0;
    end else begin
      ra_q    <= rd_addr;
      oor_q   <= (rd_addr >= ADDR_W'(NPIX));
      ram_q   <= ram[ra_q];
      oor_q2  <= oor_q;
      rd_data <= oor_q2 ? '0 : $signed(ram_q);
      rd_err  <= oor_q2;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_q    <= '0;
      ram_q   <= '0;
      rd_data <= '0;
    end else begin
      ra_q    <= rd_addr;
      ram_q   <= ram[ra_q];
      rd_data <= $signed(ram_q);
    end
  end
`endif
endmodule

// File: tb/tb_integral_image_builder.sv
// Directed bench for integral_image_builder: constant frames, overrun restart,
// mid-build reset, a gapped random frame against a reference model.
module tb_integral_image_builder;
  localparam int W    = 160;
  localparam int H    = 120;
  localparam int NPIX = W * H;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pix_valid = 1'b0;
  logic [3:0]        pix_data = '0;
  logic              frame_start = 1'b0;
  logic [14:0]       rd_addr = '0;
  logic signed [20:0] rd_data;
  logic              frame_ready, build_busy, overrun;
`ifdef II_RANGE_CHECK_EN
  logic              rd_err;
`endif

  int total = 0;
  int bad   = 0;
  int pix_mem [NPIX];
  int ii_ref  [NPIX];
  int ra[$];
  int rexp[$];

  integral_image_builder #(
    .WIDTH(W), .HEIGHT(H), .PIX_W(4), .II_W(21), .ADDR_W(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .frame_start(frame_start),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .frame_ready(frame_ready),
    .build_busy(build_busy),
    .overrun(overrun)
`ifdef II_RANGE_CHECK_EN
    ,.rd_err(rd_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic rq(input int a, input int e);
    ra.push_back(a);
    rexp.push_back(e);
  endtask

  // Back-to-back reads; each result is checked exactly 3 cycles after its address.
  task automatic do_reads();
    int n = ra.size();
    for (int i = 0; i < n + 3; i++) begin
      if (i < n) rd_addr = 15'(ra[i]);
      if (i >= 3) chk($sformatf("rd%0d", ra[i-3]), {11'd0, rd_data}, 32'(rexp[i-3]));
      tick();
    end
    ra.delete();
    rexp.delete();
  endtask

  // mode 0: all 1, mode 1: all 15, mode 2: pix_mem
  task automatic feed(input int n, input int mode, input bit gaps);
    bit gap_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == 1) begin
        chk_b("fr_fall", frame_ready, 1'b0);
        chk_b("busy_in_build", build_busy, 1'b1);
      end
      if (i == NPIX - 1) chk_b("fr_early", frame_ready, 1'b0);
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
        pix_valid = 1'b0;
        frame_start = 1'b0;
        pix_data = 4'hF;
        tick();
        if (!gap_seen) begin
          chk_b("stall_busy", build_busy, 1'b1);
          chk_b("stall_fr", frame_ready, 1'b0);
          gap_seen = 1'b1;
        end
      end
      pix_valid = 1'b1;
      frame_start = (i == 0);
      if (mode == 0)      pix_data = 4'd1;
      else if (mode == 1) pix_data = 4'd15;
      else                pix_data = 4'(pix_mem[i]);
      tick();
    end
  endtask

  task automatic finish_frame(input string tag);
    pix_valid = 1'b0;
    frame_start = 1'b0;
    chk_b({tag, "_fr_plus1"}, frame_ready, 1'b0);
    tick();
    chk_b({tag, "_fr_plus2"}, frame_ready, 1'b1);
    chk_b({tag, "_busy_done"}, build_busy, 1'b0);
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_rd_data", {11'd0, rd_data}, 32'd0);
    chk_b("rst_fr", frame_ready, 1'b0);
    chk_b("rst_busy", build_busy, 1'b0);
    chk_b("rst_overrun", overrun, 1'b0);
    rst = 1'b0;

    // IDLE ignores pixels without frame_start
    pix_valid = 1'b1;
    pix_data = 4'd5;
    tick();
    tick();
    chk_b("idle_ignore", build_busy, 1'b0);
    pix_valid = 1'b0;
    tick();

    // frame of all 1
    feed(NPIX, 0, 1'b0);
    finish_frame("f1");
    rq(0, 1); rq(159, 160); rq(160, 2); rq(19199, 19200);
    do_reads();

    // READY ignores pixels without frame_start
    pix_valid = 1'b1;
    pix_data = 4'd15;
    tick(); tick(); tick();
    pix_valid = 1'b0;
    chk_b("ready_ignore_busy", build_busy, 1'b0);
    chk_b("ready_ignore_fr", frame_ready, 1'b1);
    rq(0, 1); rq(1, 2);
    do_reads();

    // all 15, restarted at pixel 500
    feed(500, 1, 1'b0);
    chk_b("pre_restart_overrun", overrun, 1'b0);
    feed(NPIX, 1, 1'b0);
    chk_b("overrun_set", overrun, 1'b1);
    finish_frame("f2");
    rq(19199, 288000); rq(161, 60); rq(0, 15); rq(1, 30);
    rq(160, 30); rq(159, 2400); rq(320, 45);
    do_reads();

    // reset mid-build
    feed(7000, 0, 1'b0);
    pix_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_rd_data", {11'd0, rd_data}, 32'd0);
    chk_b("midrst_fr", frame_ready, 1'b0);
    chk_b("midrst_busy", build_busy, 1'b0);
    chk_b("midrst_overrun", overrun, 1'b0);
    rst = 1'b0;
    tick();

    // random frame with stalls against a reference model
    for (int i = 0; i < NPIX; i++) pix_mem[i] = $urandom_range(0, 15);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        int v;
        v = pix_mem[yy*W + xx];
        if (xx > 0) v += ii_ref[yy*W + xx - 1];
        if (yy > 0) v += ii_ref[(yy-1)*W + xx];
        if (xx > 0 && yy > 0) v -= ii_ref[(yy-1)*W + xx - 1];
        ii_ref[yy*W + xx] = v;
      end
    feed(NPIX, 2, 1'b1);
    finish_frame("f3");
    chk_b("f3_no_overrun", overrun, 1'b0);
    for (int a = 0; a < NPIX; a += 37) rq(a, ii_ref[a]);
    rq(W - 1, ii_ref[W-1]); rq(W, ii_ref[W]); rq(NPIX - 1, ii_ref[NPIX-1]);
    do_reads();

`ifdef II_RANGE_CHECK_EN
    rd_addr = 15'd19200;
    tick();
    rd_addr = 15'd19199;
    tick();
    tick();
    chk("oor_data", {11'd0, rd_data}, 32'd0);
    chk_b("oor_err", rd_err, 1'b1);
    tick();
    chk("inrange_data", {11'd0, rd_data}, 32'(ii_ref[NPIX-1]));
    chk_b("inrange_err", rd_err, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
